// File: rtl/ldst_request_issuer_pkg.sv
// rtl/ldst_request_issuer_pkg.sv - shared types and constants for the load/store request issuer
package ldst_request_issuer_pkg;

  localparam int ID_W       = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } entry_state_e;

  typedef struct packed {
    entry_state_e            state;
    logic                    rw;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   data;
  } entry_t;

  // Wrap at DEPTH-1 rather than relying on ID_W overflow, so smaller rings work.
  function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] p, input int depth);
    return (p == ID_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/ldst_request_issuer_if.sv
// rtl/ldst_request_issuer_if.sv - pipeline, memory_system and retire signal bundle
interface ldst_request_issuer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import ldst_request_issuer_pkg::*;

  logic              enq_valid_in;
  logic              enq_rw_in;
  logic [ADDR_W-1:0] enq_addr_in;
  logic [DATA_W-1:0] enq_data_in;
  logic              enq_ready_out;
  logic [ID_W-1:0]   enq_id_out;

  logic              mem_valid_out;
  logic              mem_rw_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_data_out;
  logic [ID_W-1:0]   mem_id_out;
  logic              mem_stall_in;
  logic              mem_ready_in;
  logic [ID_W-1:0]   mem_id_in;
  logic [DATA_W-1:0] mem_data_in;

  logic              ret_valid_out;
  logic              ret_rw_out;
  logic [ID_W-1:0]   ret_id_out;
  logic [DATA_W-1:0] ret_data_out;

  logic [ID_W:0]     count_out;
  logic              err_out;

  modport slave (
    input  enq_valid_in, enq_rw_in, enq_addr_in, enq_data_in,
    output enq_ready_out, enq_id_out,
    output mem_valid_out, mem_rw_out, mem_addr_out, mem_data_out, mem_id_out,
    input  mem_stall_in, mem_ready_in, mem_id_in, mem_data_in,
    output ret_valid_out, ret_rw_out, ret_id_out, ret_data_out,
    output count_out, err_out
  );

  modport master (
    output enq_valid_in, enq_rw_in, enq_addr_in, enq_data_in,
    input  enq_ready_out, enq_id_out,
    input  mem_valid_out, mem_rw_out, mem_addr_out, mem_data_out, mem_id_out,
    output mem_stall_in, mem_ready_in, mem_id_in, mem_data_in,
    input  ret_valid_out, ret_rw_out, ret_id_out, ret_data_out,
    input  count_out, err_out
  );

endinterface

// File: rtl/ldst_request_issuer_ring_ptr.sv
// rtl/ldst_request_issuer_ring_ptr.sv - wrap-around ring pointer with increment enable
module ldst_ring_ptr
  import ldst_request_issuer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc,
  output logic [ID_W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr_next(ptr, DEPTH);
    end
  end

endmodule

// File: rtl/ldst_request_issuer.sv
// rtl/ldst_request_issuer.sv - in-order load/store queue: enqueue, issue, match responses, retire
module ldst_request_issuer
  import ldst_request_issuer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic                 clk,
  input logic                 reset_n,
  ldst_request_issuer_if.slave bus
);

  localparam logic [ID_W:0] DEPTH_C = (ID_W + 1)'(DEPTH);

  entry_t            entries [DEPTH];
  entry_t            issue_e;
  entry_t            head_e;
  logic [ID_W-1:0]   head;
  logic [ID_W-1:0]   issue;
  logic [ID_W-1:0]   tail;
  logic [ID_W:0]     count;
  logic              err;

  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;

  logic              enq_fire;
  logic              issue_fire;
  logic              rsp_hit;
  logic              rsp_fire;
  logic              rsp_miss;
  logic              ret_fire;

  assign enq_addr = bus.enq_addr_in;
  assign enq_data = bus.enq_data_in;
  assign rsp_data = bus.mem_data_in;
  assign rsp_id   = bus.mem_id_in;

  assign issue_e = entries[issue];
  assign head_e  = entries[head];

  assign enq_fire   = bus.enq_valid_in && (count < DEPTH_C);
  assign issue_fire = (issue_e.state == ST_WAIT) && !bus.mem_stall_in;

  // Only an ISSUED entry may accept a response; any other id is a protocol error.
  assign rsp_hit  = ({1'b0, rsp_id} < DEPTH_C) && (entries[rsp_id].state == ST_ISSUED);
  assign rsp_fire = bus.mem_ready_in && rsp_hit;
  assign rsp_miss = bus.mem_ready_in && !rsp_hit;

  assign ret_fire = (head_e.state == ST_DONE);

  ldst_ring_ptr #(.DEPTH(DEPTH)) u_head_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ret_fire),
    .ptr     (head)
  );

  ldst_ring_ptr #(.DEPTH(DEPTH)) u_issue_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (issue_fire),
    .ptr     (issue)
  );

  ldst_ring_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (enq_fire),
    .ptr     (tail)
  );

  // The four events always target distinct entries, so their writes never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (enq_fire) begin
        entries[tail].state <= ST_WAIT;
        entries[tail].rw    <= bus.enq_rw_in;
        entries[tail].addr  <= enq_addr;
        entries[tail].data  <= enq_data;
      end
      if (issue_fire) begin
        entries[issue].state <= ST_ISSUED;
      end
      if (rsp_fire) begin
        entries[rsp_id].state <= ST_DONE;
        if (!entries[rsp_id].rw) begin
          entries[rsp_id].data <= rsp_data;
        end
      end
      if (ret_fire) begin
        entries[head].state <= ST_FREE;
      end
      count <= count + (ID_W + 1)'(enq_fire) - (ID_W + 1)'(ret_fire);
      if (rsp_miss) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.enq_ready_out = (count < DEPTH_C);
  assign bus.enq_id_out    = tail;

  assign bus.mem_valid_out = (issue_e.state == ST_WAIT);
  assign bus.mem_rw_out    = issue_e.rw;
  assign bus.mem_addr_out  = issue_e.addr;
  assign bus.mem_data_out  = issue_e.data;
  assign bus.mem_id_out    = issue;

  assign bus.ret_valid_out = ret_fire;
  assign bus.ret_rw_out    = head_e.rw;
  assign bus.ret_id_out    = head;
  assign bus.ret_data_out  = head_e.data;

  assign bus.count_out = count;
  assign bus.err_out   = err;

endmodule

// File: tb/tb_ldst_request_issuer.sv
// tb/tb_ldst_request_issuer.sv - directed and randomized checks against a queue-level model
module tb_ldst_request_issuer;

  typedef struct {
    logic [3:0]  id;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    bit          issued;
    bit          resp;
  } op_t;

  logic clk;
  logic reset_n;

  ldst_request_issuer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ldst_request_issuer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  op_t        q[$];
  logic [3:0] next_id;
  bit         m_err;
  int         vectors;
  int         errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_unissued();
    foreach (q[i]) if (!q[i].issued) return i;
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.enq_valid_in = 1'b0;
    bus.enq_rw_in    = 1'b0;
    bus.enq_addr_in  = '0;
    bus.enq_data_in  = '0;
    bus.mem_stall_in = 1'b0;
    bus.mem_ready_in = 1'b0;
    bus.mem_id_in    = '0;
    bus.mem_data_in  = '0;
  endtask

  task automatic rand_op();
    bus.enq_valid_in = 1'b1;
    bus.enq_rw_in    = 1'($urandom_range(0, 1));
    bus.enq_addr_in  = $urandom;
    bus.enq_data_in  = $urandom;
  endtask

  task automatic check_outputs();
    int ui;
    bit rv;
    ui = first_unissued();
    rv = (q.size() > 0) && q[0].resp;
    chk("count", bus.count_out, q.size());
    chk("enq_ready", bus.enq_ready_out, q.size() < 16);
    chk("enq_id", bus.enq_id_out, next_id);
    chk("err", bus.err_out, m_err);
    chk("mem_valid", bus.mem_valid_out, ui >= 0);
    if (ui >= 0) begin
      chk("mem_id", bus.mem_id_out, q[ui].id);
      chk("mem_rw", bus.mem_rw_out, q[ui].rw);
      chk("mem_addr", bus.mem_addr_out, q[ui].addr);
      chk("mem_data", bus.mem_data_out, q[ui].data);
    end
    chk("ret_valid", bus.ret_valid_out, rv);
    if (rv) begin
      chk("ret_id", bus.ret_id_out, q[0].id);
      chk("ret_rw", bus.ret_rw_out, q[0].rw);
      chk("ret_data", bus.ret_data_out, q[0].rw ? q[0].data : q[0].rdata);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic apply_edge();
    int  pre_size;
    int  ui;
    bit  ret_f;
    bit  found;
    op_t n;
    pre_size = q.size();
    ui       = first_unissued();
    ret_f    = (pre_size > 0) && q[0].resp;
    if (bus.mem_ready_in) begin
      found = 0;
      foreach (q[i]) begin
        if (!found && q[i].id == bus.mem_id_in && q[i].issued && !q[i].resp) begin
          q[i].resp = 1;
          if (!q[i].rw) q[i].rdata = bus.mem_data_in;
          found = 1;
        end
      end
      if (!found) m_err = 1;
    end
    if (ui >= 0 && !bus.mem_stall_in) q[ui].issued = 1;
    if (ret_f) void'(q.pop_front());
    if (bus.enq_valid_in && pre_size < 16) begin
      n.id     = next_id;
      n.rw     = bus.enq_rw_in;
      n.addr   = bus.enq_addr_in;
      n.data   = bus.enq_data_in;
      n.rdata  = '0;
      n.issued = 0;
      n.resp   = 0;
      q.push_back(n);
      next_id++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    apply_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    q.delete();
    m_err   = 0;
    next_id = '0;
    #1;
    check_outputs();
    chk("rst_count", bus.count_out, 0);
    chk("rst_enq_ready", bus.enq_ready_out, 1);
    chk("rst_mem_valid", bus.mem_valid_out, 0);
    chk("rst_ret_valid", bus.ret_valid_out, 0);
    chk("rst_err", bus.err_out, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && q.size() > 0; k++) begin
      bit picked;
      clear_inputs();
      picked = 0;
      foreach (q[i]) begin
        if (!picked && q[i].issued && !q[i].resp) begin
          bus.mem_ready_in = 1'b1;
          bus.mem_id_in    = q[i].id;
          bus.mem_data_in  = $urandom;
          picked = 1;
        end
      end
      cycle();
    end
    clear_inputs();
    chk("drain_empty", bus.count_out, 0);
  endtask

  initial begin
    logic [3:0] cand[$];
    vectors = 0;
    errors  = 0;
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Single load, no stall
    bus.enq_valid_in = 1'b1;
    bus.enq_addr_in  = 32'h40;
    cycle();
    clear_inputs();
    chk("t1_mem_valid", bus.mem_valid_out, 1);
    chk("t1_mem_id", bus.mem_id_out, 0);
    chk("t1_mem_addr", bus.mem_addr_out, 32'h40);
    cycle();
    chk("t1_issued", bus.mem_valid_out, 0);
    bus.mem_ready_in = 1'b1;
    bus.mem_id_in    = 4'd0;
    bus.mem_data_in  = 32'hDEADBEEF;
    chk("t1_no_bypass", bus.ret_valid_out, 0);
    cycle();
    clear_inputs();
    chk("t1_ret_valid", bus.ret_valid_out, 1);
    chk("t1_ret_id", bus.ret_id_out, 0);
    chk("t1_ret_data", bus.ret_data_out, 32'hDEADBEEF);
    cycle();
    chk("t1_empty", bus.count_out, 0);

    // Fill under stall, hold the 17th, then release
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rand_op();
      bus.mem_stall_in = 1'b1;
      cycle();
    end
    chk("full_ready", bus.enq_ready_out, 0);
    chk("full_count", bus.count_out, 16);
    rand_op();
    bus.mem_stall_in = 1'b1;
    cycle();
    cycle();
    chk("held_count", bus.count_out, 16);
    clear_inputs();
    for (int i = 0; i < 16; i++) begin
      chk("burst_valid", bus.mem_valid_out, 1);
      chk("burst_id", bus.mem_id_out, i);
      cycle();
    end
    bus.mem_ready_in = 1'b1;
    bus.mem_id_in    = 4'd2;
    bus.mem_data_in  = $urandom;
    cycle();
    bus.mem_id_in    = 4'd0;
    bus.mem_data_in  = $urandom;
    cycle();
    chk("ooo_ret0_valid", bus.ret_valid_out, 1);
    chk("ooo_ret0_id", bus.ret_id_out, 0);
    bus.mem_id_in    = 4'd1;
    bus.mem_data_in  = $urandom;
    cycle();
    chk("ooo_ret1_id", bus.ret_id_out, 1);
    for (int i = 3; i < 16; i++) begin
      bus.mem_id_in   = 4'(i);
      bus.mem_data_in = $urandom;
      cycle();
      if (i == 3) chk("ooo_ret2_id", bus.ret_id_out, 2);
    end
    drain();

    // Same-cycle enqueue, issue, response and retire at count 5
    for (int i = 0; i < 5; i++) begin
      rand_op();
      bus.mem_stall_in = 1'b1;
      cycle();
    end
    clear_inputs();
    repeat (3) cycle();
    bus.mem_stall_in = 1'b1;
    bus.mem_ready_in = 1'b1;
    bus.mem_id_in    = 4'd0;
    bus.mem_data_in  = $urandom;
    cycle();
    clear_inputs();
    rand_op();
    bus.mem_ready_in = 1'b1;
    bus.mem_id_in    = 4'd1;
    bus.mem_data_in  = $urandom;
    chk("quad_pre_count", bus.count_out, 5);
    chk("quad_pre_ret", bus.ret_id_out, 0);
    chk("quad_pre_mem_id", bus.mem_id_out, 3);
    cycle();
    clear_inputs();
    chk("quad_count", bus.count_out, 5);
    chk("quad_ret_valid", bus.ret_valid_out, 1);
    chk("quad_ret_id", bus.ret_id_out, 1);
    chk("quad_mem_id", bus.mem_id_out, 4);
    chk("quad_enq_id", bus.enq_id_out, 6);
    drain();

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      clear_inputs();
      if ($urandom_range(0, 2) != 0) rand_op();
      bus.mem_stall_in = ($urandom_range(0, 3) == 0);
      cand.delete();
      foreach (q[i]) if (q[i].issued && !q[i].resp) cand.push_back(q[i].id);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.mem_ready_in = 1'b1;
        bus.mem_id_in    = cand[$urandom_range(0, cand.size() - 1)];
        bus.mem_data_in  = $urandom;
      end
      cycle();
    end
    drain();

    // Response to a FREE entry
    bus.mem_ready_in = 1'b1;
    bus.mem_id_in    = 4'd7;
    bus.mem_data_in  = $urandom;
    cycle();
    clear_inputs();
    chk("err_set", bus.err_out, 1);
    chk("err_no_ret", bus.ret_valid_out, 0);
    cycle();
    cycle();
    chk("err_sticky", bus.err_out, 1);

    // Reset with three entries in flight
    for (int i = 0; i < 3; i++) begin
      rand_op();
      cycle();
    end
    clear_inputs();
    cycle();
    chk("pre_rst_count", bus.count_out, 3);
    chk("pre_rst_mem_valid", bus.mem_valid_out, 0);
    do_reset();
    bus.mem_ready_in = 1'b1;
    bus.mem_id_in    = 4'd1;
    bus.mem_data_in  = $urandom;
    cycle();
    clear_inputs();
    chk("stale_rsp_err", bus.err_out, 1);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
